// File: rtl/pipe_host_ctrl.sv
// Run/halt sequencer and memory-port arbiter between the mini-processor pipeline and the host.
// Optional single-step support is enabled by defining HOST_SSTEP_EN.
module pipe_host_ctrl #(
  parameter int ADDR_W       = 9,
  parameter int DRAIN_CYCLES = 4,
  parameter bit BOOT_HALTED  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_cmd_halt,
  input  logic              host_cmd_run,
  input  logic              host_cmd_step,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [63:0]       host_wdata,
  output logic [63:0]       host_rdata,
  output logic              host_ack,
  output logic              halted,
  output logic              pc_hold,
  output logic              fetch_bubble,
  input  logic [ADDR_W-1:0] pipe_imem_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_din,
  input  logic [31:0]       imem_dout,
  input  logic [ADDR_W-1:0] pipe_dmem_addr,
  input  logic              pipe_dmem_we,
  input  logic [63:0]       pipe_dmem_din,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [63:0]       dmem_din,
  input  logic [63:0]       dmem_dout
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_HALTED = 3'd2;
  localparam logic [2:0] S_H_ACC  = 3'd3;
  localparam logic [2:0] S_H_RD   = 3'd4;
  localparam logic [2:0] S_H_DONE = 3'd5;
`ifdef HOST_SSTEP_EN
  localparam logic [2:0] S_STEP   = 3'd6;
`endif
  localparam logic [2:0] S_BOOT   = BOOT_HALTED ? S_HALTED : S_RUN;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] drain_cnt, cnt_nxt;
  logic             pipe_owns;
  logic             pipe_fetch;

`ifndef HOST_SSTEP_EN
  logic unused_step;
  assign unused_step = host_cmd_step;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = drain_cnt;
    case (state)
      S_RUN: begin
        if (host_cmd_halt) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) state_nxt = S_HALTED;
        else                 cnt_nxt   = drain_cnt - CNT_ONE;
      end
      S_HALTED: begin
        if (host_req)          state_nxt = S_H_ACC;
`ifdef HOST_SSTEP_EN
        else if (host_cmd_step) state_nxt = S_STEP;
`endif
        else if (host_cmd_run) state_nxt = S_RUN;
      end
      S_H_ACC:  state_nxt = S_H_RD;
      S_H_RD:   state_nxt = S_H_DONE;
      // Waiting for req to drop guarantees one access per req assertion.
      S_H_DONE: if (!host_req) state_nxt = S_HALTED;
`ifdef HOST_SSTEP_EN
      S_STEP: begin
        state_nxt = S_DRAIN;
        cnt_nxt   = DRAIN_LOAD;
      end
`endif
      default:  state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_BOOT;
      drain_cnt  <= '0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= cnt_nxt;
      host_ack  <= (state == S_H_RD);
      if (state == S_H_RD && !host_we)
        host_rdata <= host_sel ? dmem_dout : {32'h0, imem_dout};
    end
  end

`ifdef HOST_SSTEP_EN
  assign pipe_fetch = (state == S_RUN) || (state == S_STEP);
`else
  assign pipe_fetch = (state == S_RUN);
`endif
  assign pipe_owns    = pipe_fetch || (state == S_DRAIN);
  assign pc_hold      = !pipe_fetch;
  assign fetch_bubble = !pipe_fetch;
  assign halted       = (state == S_HALTED) || (state == S_H_ACC) ||
                        (state == S_H_RD)   || (state == S_H_DONE);

  // Host addresses stay on the ports in every host-owned state; only H_ACC may write.
  always_comb begin
    imem_addr = host_addr;
    imem_we   = 1'b0;
    imem_din  = host_wdata[31:0];
    dmem_addr = host_addr;
    dmem_we   = 1'b0;
    dmem_din  = host_wdata;
    if (pipe_owns) begin
      imem_addr = pipe_imem_addr;
      imem_din  = '0;
      dmem_addr = pipe_dmem_addr;
      dmem_we   = pipe_dmem_we;
      dmem_din  = pipe_dmem_din;
    end else if (state == S_H_ACC) begin
      imem_we = host_we && !host_sel;
      dmem_we = host_we && host_sel;
    end
  end

endmodule

// File: doc/pipe_host_ctrl.md
# pipe_host_ctrl

Run/halt sequencer and memory-port arbiter between the 5-stage mini-processor pipeline and the host register interface. Halts the pipeline by freezing fetch and draining in-flight instructions. While halted, hands the instruction and data memory ports to the host for single-word program load and data readback, then resumes the pipeline. Sits between the IF stage / PC register, the two synchronous BRAMs and the host register block.

## Interface
- ADDR_W, 9: word-address width of both memories (matches the 9-bit PC).
- DRAIN_CYCLES, 4: cycles of fetch suppression required to retire every in-flight instruction.
- BOOT_HALTED, 1: 1 = leave reset in HALTED, 0 = leave reset in RUN.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- host_cmd_halt  in  1  one-cycle halt request.
- host_cmd_run  in  1  one-cycle resume request.
- host_cmd_step  in  1  one-cycle single-step request (see Configuration).
- host_req  in  1  host memory access request, level; held until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_sel  in  1  0 = imem, 1 = dmem.
- host_addr  in  ADDR_W  word address.
- host_wdata  in  64  write data; imem uses [31:0].
- host_rdata  out  64  registered read data; imem read zero-extended.
- host_ack  out  1  one-cycle completion pulse.
- halted  out  1  pipeline stopped, host owns memories.
- pc_hold  out  1  PC register must not advance. An EX redirect still loads the PC.
- fetch_bubble  out  1  IF/ID loads a NOP instead of imem_dout.
- pipe_imem_addr  in  ADDR_W  fetch address from the PC.
- imem_addr  out  ADDR_W  to imem.
- imem_we  out  1  to imem.
- imem_din  out  32  to imem.
- imem_dout  in  32  from imem (1-cycle read latency).
- pipe_dmem_addr  in  ADDR_W  from MEM stage.
- pipe_dmem_we  in  1  from MEM stage.
- pipe_dmem_din  in  64  from MEM stage.
- dmem_addr  out  ADDR_W  to dmem.
- dmem_we  out  1  to dmem.
- dmem_din  out  64  to dmem.
- dmem_dout  in  64  from dmem (1-cycle read latency).

## Operation
- States: RUN, DRAIN, HALTED, H_ACC, H_RD, H_DONE, STEP (STEP exists only with the macro).
- RUN: pc_hold=0, fetch_bubble=0, halted=0. The pipeline owns both ports.
  - host_cmd_halt moves the block to DRAIN and loads drain_cnt=DRAIN_CYCLES-1.
  - If halt and run arrive in the same cycle, halt wins.
- DRAIN: pc_hold=1, fetch_bubble=1. The pipeline still owns both ports, so stores in flight complete.
  - drain_cnt decrements each cycle. At 0 the block moves to HALTED.
  - All commands are ignored.
- HALTED: halted=1, pc_hold=1, fetch_bubble=1. The host owns both ports with we=0.
  - Priority: host_req over host_cmd_step over host_cmd_run.
  - host_req moves to H_ACC. host_cmd_run moves to RUN. host_cmd_halt is ignored.
- H_ACC: drive the selected port with host_addr and host_we. imem_din=host_wdata[31:0]; dmem_din=host_wdata. The unselected port gets we=0. Next state is H_RD.
- H_RD: the selected port address is held, we=0.
  - On a read, host_rdata takes the selected dout at the closing edge. On a write, host_rdata is unchanged.
  - host_ack is set for the next cycle. Next state is H_DONE.
- H_DONE: host_ack=1 for exactly this cycle only. The block waits for host_req=0, then moves to HALTED, so one access is performed per req assertion.
- host_req raised in RUN or DRAIN is not acknowledged until the block reaches HALTED.
- Port mux: RUN, DRAIN and STEP pass the pipe_* signals through. All other states use the host (or idle) values.
- halted, pc_hold and fetch_bubble are decoded from the state register only (Moore outputs).

## Timing
- Reset (any state, mid-access included):
  - state = HALTED if BOOT_HALTED=1, else RUN.
  - drain_cnt=0, host_rdata=0, host_ack=0.
  - No memory write occurs in the cycle after reset.
- Halt: a pulse in cycle 0 gives pc_hold=1 in cycle 1 and halted=1 in cycle DRAIN_CYCLES+1.
- Run: a pulse in HALTED cycle 0 gives halted=0 and pc_hold=0 in cycle 1.
- Host access: req seen in HALTED cycle h.
  - Memory we/addr are driven in cycle h+1.
  - dout is captured at the end of h+2.
  - host_ack and valid host_rdata appear in h+3.
  - The earliest next access starts 2 cycles after req falls.

## Configuration
- HOST_SSTEP_EN defined:
  - host_cmd_step in HALTED moves to STEP for one cycle: pc_hold=0, fetch_bubble=0, pipeline owns the ports, exactly one instruction is fetched.
  - STEP then moves to DRAIN with drain_cnt=DRAIN_CYCLES-1, and then to HALTED.
- HOST_SSTEP_EN undefined: the STEP state does not exist and host_cmd_step is ignored in every state.

## Test plan
- Reset, BOOT_HALTED=1; write imem addr 5 = 0xE0811002:
  - halted=1 and pc_hold=1 in the cycle after reset.
  - imem_we=1 for exactly one cycle with imem_addr=5 and imem_din=0xE0811002.
  - host_ack pulses 3 cycles after req.
- Preload dmem[3]=0x1234; read host_sel=1, addr 3:
  - host_rdata=0x0000000000001234 in the host_ack cycle.
  - dmem_we stays 0.
- Run pulse, then halt pulse at cycle 0, with pipe_dmem_we=1 to addr 7 in cycle 2:
  - dmem_we=1 with addr 7 in cycle 2.
  - halted rises in cycle 5.
- host_req raised in RUN:
  - No host_ack and no host write until a halt completes.
  - The access then completes 3 cycles after halted rises.
- host_cmd_halt and host_cmd_run in the same RUN cycle: DRAIN is entered.
- Reset asserted during H_RD: no host_ack, host_rdata=0, state=HALTED.
- With HOST_SSTEP_EN, step in HALTED:
  - fetch_bubble=0 for exactly one cycle.
  - halted returns after DRAIN_CYCLES+1 cycles.
- Without HOST_SSTEP_EN, the same step pulse leaves halted=1 throughout.
